// File: rtl/alu_pkg.sv
// Shared types for seq_alu: operation codes, control FSM states, iterative engine
// mode, and the helper that tells single-cycle ops from multi-cycle ones.
package alu_pkg;

    // Codes 12..15 are deliberately absent; they decode as "undefined".
    typedef enum logic [3:0] {
        OpAnd  = 4'd0,
        OpOr   = 4'd1,
        OpAdd  = 4'd2,
        OpNor  = 4'd3,
        OpSll  = 4'd4,
        OpSrl  = 4'd5,
        OpSub  = 4'd6,
        OpSlt  = 4'd7,
        OpSltu = 4'd8,
        OpMulu = 4'd9,
        OpDivu = 4'd10,
        OpSra  = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic {
        ModeMul = 1'b0,
        ModeDiv = 1'b1
    } md_mode_e;

    function automatic logic is_multicycle(logic [3:0] op);
        return (op == OpMulu) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   start         - load operands and begin WIDTH iterations
//   mode          - ModeMul or ModeDiv, sampled on start
//   a, b          - operands, sampled on start
//   done          - one-cycle pulse once the result in hi/lo is final
//   hi, lo        - MUL: product high/low; DIV: remainder/quotient
//   dbz           - divisor captured on start was zero
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_mode_e         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    md_mode_e         mode_q, mode_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;

    always_comb begin
        // MUL: {hi, lo} is the product register, lo starts as the multiplier.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        // DIV: hi is the partial remainder, lo shifts dividend out / quotient in.
        div_shift = {hi_q, lo_q[WIDTH-1]};
        // Remainder stays below the divisor, so the low WIDTH bits are exact; with a
        // zero divisor the remainder simply accumulates the dividend.
        div_diff  = div_shift[WIDTH-1:0] - opb_q;

        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = done_q;
        mode_d   = mode_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;

        if (start) begin
            active_d = 1'b1;
            done_d   = 1'b0;
            cnt_d    = '0;
            mode_d   = mode;
            hi_d     = '0;
            lo_d     = a;
            opb_d    = b;
        end else if (done_q) begin
            active_d = 1'b0;
            done_d   = 1'b0;
        end else if (active_q) begin
            if (mode_q == ModeMul) begin
                {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
            end else if (div_shift >= {1'b0, opb_q}) begin
                hi_d = div_diff;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= ModeMul;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dbz  = (opb_q == '0);

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered results and an iterative MULU/DIVU engine.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   in_valid/in_ready       - request handshake; op, a, b sampled on transfer
//   out_valid/out_ready     - result handshake
//   result, result_hi       - LO/quotient and HI/remainder (HI is 0 for other ops)
//   zero, overflow, carry_out - status of the held result
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d;
    logic             is_div_q, is_div_d;

    logic [WIDTH:0]   add_full, sub_full;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf, sc_carry, sc_defined;

    logic             in_fire, mc, md_start, md_done, md_dbz;
    logic [WIDTH-1:0] md_hi, md_lo;

    // Single-cycle combinational unit.
    always_comb begin
        add_full   = {1'b0, a} + {1'b0, b};
        sub_full   = {1'b0, a} - {1'b0, b};  // bit WIDTH set means borrow
        shamt      = b[SHW-1:0];
        sc_res     = '0;
        sc_ovf     = 1'b0;
        sc_carry   = 1'b0;
        sc_defined = 1'b1;
        case (op)
            OpAnd: sc_res = a & b;
            OpOr:  sc_res = a | b;
            OpNor: sc_res = ~(a | b);
            OpAdd: begin
                sc_res   = add_full[WIDTH-1:0];
                sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
                sc_carry = add_full[WIDTH];
            end
            OpSub: begin
                sc_res   = sub_full[WIDTH-1:0];
                sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
                sc_carry = ~sub_full[WIDTH];
            end
            OpSll:  sc_res = a << shamt;
            OpSrl:  sc_res = a >> shamt;
            OpSra:  sc_res = $unsigned($signed(a) >>> shamt);
            OpSlt:  sc_res = {{(WIDTH - 1){1'b0}}, ($signed(a) < $signed(b))};
            OpSltu: sc_res = {{(WIDTH - 1){1'b0}}, (a < b)};
            OpMulu, OpDivu: sc_res = '0;  // produced by the iterative engine
            default: sc_defined = 1'b0;
        endcase
    end

    assign mc       = is_multicycle(op);
    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign in_fire  = in_valid && in_ready;
    assign md_start = in_fire && mc;

    iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk  (clk),
        .reset(reset),
        .start(md_start),
        .mode ((op == OpDivu) ? ModeDiv : ModeMul),
        .a    (a),
        .b    (b),
        .done (md_done),
        .hi   (md_hi),
        .lo   (md_lo),
        .dbz  (md_dbz)
    );

    // Next state and result capture.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        carry_d  = carry_q;
        is_div_d = is_div_q;

        case (state_q)
            StIdle: if (in_fire) state_d = mc ? StBusy : StDone;
            StBusy: if (md_done) state_d = StDone;
            StDone: if (out_ready) state_d = in_fire ? (mc ? StBusy : StDone) : StIdle;
            default: state_d = StIdle;
        endcase

        if (md_start) begin
            is_div_d = (op == OpDivu);
        end

        if (in_fire && !mc) begin
            res_d    = sc_res;
            res_hi_d = '0;
            // Undefined ops report all flags clear, including zero.
            zero_d   = sc_defined && (sc_res == '0);
            ovf_d    = sc_ovf;
            carry_d  = sc_carry;
        end else if ((state_q == StBusy) && md_done) begin
            res_d    = md_lo;
            res_hi_d = md_hi;
            zero_d   = (md_lo == '0) && (md_hi == '0);
            ovf_d    = is_div_q ? md_dbz : (md_hi != '0);
            carry_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            carry_q  <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            carry_q  <= carry_d;
            is_div_q <= is_div_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign result    = res_q;
    assign result_hi = res_hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = carry_q;

endmodule
